// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and default sizes for the APB request arbiter.
// Pure declarations; no latency or backpressure of its own.
package apb_arb_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_ADDR_W         = 32;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_SETUP  = 2'b01,
      ST_ACCESS = 2'b10,
      ST_DONE   = 2'b11
   } apb_arb_state_t;

endpackage

// File: rtl/apb_req_arbiter_if.sv
// APB master-side bus bundle; master drives the request phase, slave answers.
// Wires only; PREADY low stretches the ACCESS phase.
interface apb_req_arbiter_if
   import apb_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              psel_o;
   logic              penable_o;
   logic [ADDR_W-1:0] paddr_o;
   logic              pwrite_o;
   logic [DATA_W-1:0] pwdata_o;
   logic [DATA_W-1:0] prdata_i;
   logic              pready_i;

   modport master (
      output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
      input  prdata_i, pready_i
   );

   modport slave (
      input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o,
      output prdata_i, pready_i
   );
endinterface

// File: rtl/apb_req_arbiter_rr.sv
// Round-robin pick: first requesting index strictly after last_ptr, wrapping.
// Combinational, zero latency; no backpressure.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] last_ptr,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] grant_idx,
   output logic                 grant_vld
);
   localparam int IDX_W = $clog2(N);

   logic [IDX_W-1:0] pos;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      grant_vld = 1'b0;
      pos       = last_ptr;
      for (int i = 0; i < N; i++) begin
         pos = (pos == IDX_W'(N - 1)) ? '0 : pos + 1'b1;
         if (!grant_vld && req[pos]) begin
            grant_vld = 1'b1;
            grant_idx = pos;
         end
      end
      if (grant_vld) grant[grant_idx] = 1'b1;
   end
endmodule

// File: rtl/apb_req_arbiter.sv
// Shares one APB master among NUM_REQ requesters; grant in IDLE, done 3+waits cycles later.
// PREADY stretches ACCESS; define APB_TIMEOUT_EN to abort long ACCESS phases with err_o.
module apb_req_arbiter
   import apb_arb_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                      pclk,
   input  logic                      preset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ-1:0]        req_write_i,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic [NUM_REQ-1:0]        done_o,
   output logic [DATA_W-1:0]         rdata_o,
   output logic                      err_o,
   apb_req_arbiter_if.master         apb
);
   localparam int IDX_W = $clog2(NUM_REQ);

   apb_arb_state_t    state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  idx;
   logic              psel_q;
   logic              penable_q;
   logic [ADDR_W-1:0] paddr_q;
   logic              pwrite_q;
   logic [DATA_W-1:0] pwdata_q;
   logic [NUM_REQ-1:0] done_q;
   logic [DATA_W-1:0] rdata_q;
   logic              access_abort;

   logic [NUM_REQ-1:0] arb_gnt;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_vld;
   logic               sel_write;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .req       (req_i),
      .last_ptr  (ptr),
      .grant     (arb_gnt),
      .grant_idx (arb_idx),
      .grant_vld (arb_vld)
   );

   always_comb begin
      sel_write = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (arb_idx == IDX_W'(k)) begin
            sel_write = req_write_i[k];
            sel_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
            sel_wdata = req_wdata_i[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef APB_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TMO_W-1:0] tmo_cnt;
   logic             err_q;

   // Abort on the TIMEOUT_CYCLES-th ACCESS cycle that still lacks PREADY.
   assign access_abort = (state == ST_ACCESS) && !apb.pready_i &&
                         (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge pclk) begin
      if (preset) begin
         tmo_cnt <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state == ST_SETUP)
            tmo_cnt <= '0;
         else if (state == ST_ACCESS && !apb.pready_i)
            tmo_cnt <= tmo_cnt + 1'b1;
         err_q <= access_abort;
      end
   end

   assign err_o = err_q;
`else
   assign access_abort = 1'b0;
   assign err_o        = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (preset) begin
         state     <= ST_IDLE;
         ptr       <= IDX_W'(NUM_REQ - 1);
         idx       <= '0;
         psel_q    <= 1'b0;
         penable_q <= 1'b0;
         paddr_q   <= '0;
         pwrite_q  <= 1'b0;
         pwdata_q  <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_vld) begin
                  idx      <= arb_idx;
                  ptr      <= arb_idx;
                  psel_q   <= 1'b1;
                  paddr_q  <= sel_addr;
                  pwrite_q <= sel_write;
                  pwdata_q <= sel_write ? sel_wdata : '0;
                  state    <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               penable_q <= 1'b1;
               state     <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb.pready_i || access_abort) begin
                  rdata_q   <= (apb.pready_i && !pwrite_q) ? apb.prdata_i : '0;
                  done_q    <= NUM_REQ'(1) << idx;
                  psel_q    <= 1'b0;
                  penable_q <= 1'b0;
                  paddr_q   <= '0;
                  pwrite_q  <= 1'b0;
                  pwdata_q  <= '0;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               done_q  <= '0;
               rdata_q <= '0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Grant is combinational but never shown while reset discards the capture.
   assign gnt_o         = (state == ST_IDLE && !preset) ? arb_gnt : '0;
   assign done_o        = done_q;
   assign rdata_o       = rdata_q;
   assign apb.psel_o    = psel_q;
   assign apb.penable_o = penable_q;
   assign apb.paddr_o   = paddr_q;
   assign apb.pwrite_o  = pwrite_q;
   assign apb.pwdata_o  = pwdata_q;
endmodule

// File: tb/tb_apb_req_arbiter.sv
// Bench for apb_req_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized requester traffic.
module tb_apb_req_arbiter;
   localparam int NR  = 4;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 16;

   logic              pclk;
   logic              preset;
   logic [NR-1:0]     req;
   logic [NR-1:0]     req_write;
   logic [NR*AW-1:0]  req_addr;
   logic [NR*DW-1:0]  req_wdata;
   logic [NR-1:0]     gnt;
   logic [NR-1:0]     done;
   logic [DW-1:0]     rdata;
   logic              err;

   apb_req_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   apb_req_arbiter #(
      .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .pclk        (pclk),
      .preset      (preset),
      .req_i       (req),
      .req_write_i (req_write),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .gnt_o       (gnt),
      .done_o      (done),
      .rdata_o     (rdata),
      .err_o       (err),
      .apb         (bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Transaction-level model: the transfer in flight and its age in cycles since grant.
   bit            m_valid = 1'b0;
   bit            m_busy  = 1'b0;
   bit            m_fin   = 1'b0;
   int            m_age   = 0;
   int            m_ptr   = NR - 1;
   int            m_idx   = 0;
   bit            m_write = 1'b0;
   bit            m_err   = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;
   logic [NR-1:0] e_gnt   = '0;
   logic [NR-1:0] e_done  = '0;

   task automatic check(string nm, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
      end
   endtask

   function automatic int winner(logic [NR-1:0] r, int p);
      for (int i = 1; i <= NR; i++) begin
         if (r[(p + i) % NR]) return (p + i) % NR;
      end
      return -1;
   endfunction

   task automatic sample();
      int            w;
      logic [NR-1:0] x_gnt, x_done;
      logic [DW-1:0] x_rdata, x_pwdata;
      logic [AW-1:0] x_paddr;
      logic          x_err, x_psel, x_pen, x_pwrite;
      @(negedge pclk);
      cyc++;
      x_gnt = '0; x_done = '0; x_rdata = '0; x_pwdata = '0; x_paddr = '0;
      x_err = 1'b0; x_psel = 1'b0; x_pen = 1'b0; x_pwrite = 1'b0;
      w = winner(req, m_ptr);
      if (!m_busy) begin
         if (w >= 0 && !preset && m_valid) x_gnt[w] = 1'b1;
      end else if (m_fin) begin
         x_done[m_idx] = 1'b1;
         x_rdata = m_rdata;
         x_err   = m_err;
      end else begin
         x_psel   = 1'b1;
         x_pen    = (m_age >= 2);
         x_paddr  = m_addr;
         x_pwrite = m_write;
         x_pwdata = m_write ? m_wdata : '0;
      end
      e_gnt  = x_gnt;
      e_done = x_done;
      if (m_valid) begin
         check("gnt", 64'(gnt), 64'(x_gnt));
         check("done", 64'(done), 64'(x_done));
         check("rdata", 64'(rdata), 64'(x_rdata));
         check("err", 64'(err), 64'(x_err));
         check("psel", 64'(bus.psel_o), 64'(x_psel));
         check("penable", 64'(bus.penable_o), 64'(x_pen));
         check("paddr", 64'(bus.paddr_o), 64'(x_paddr));
         check("pwrite", 64'(bus.pwrite_o), 64'(x_pwrite));
         check("pwdata", 64'(bus.pwdata_o), 64'(x_pwdata));
      end
      if (preset) begin
         m_busy = 1'b0; m_fin = 1'b0; m_ptr = NR - 1; m_valid = 1'b1;
      end else if (m_valid) begin
         if (!m_busy) begin
            if (w >= 0) begin
               m_busy = 1'b1; m_fin = 1'b0; m_age = 1; m_err = 1'b0;
               m_idx = w; m_ptr = w;
               m_write = req_write[w];
               m_addr  = req_addr[w*AW +: AW];
               m_wdata = req_wdata[w*DW +: DW];
            end
         end else if (m_fin) begin
            m_busy = 1'b0;
         end else begin
            if (m_age >= 2) begin
               if (bus.pready_i) begin
                  m_fin = 1'b1; m_err = 1'b0;
                  m_rdata = m_write ? '0 : bus.prdata_i;
               end
`ifdef APB_TIMEOUT_EN
               else if (m_age - 1 >= TMO) begin
                  m_fin = 1'b1; m_err = 1'b1; m_rdata = '0;
               end
`endif
            end
            m_age++;
         end
      end
   endtask

   task automatic adv();
      @(posedge pclk);
      #1;
   endtask

   task automatic set_req(int k, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
      req[k]              = 1'b1;
      req_write[k]        = wr;
      req_addr[k*AW +: AW] = a;
      req_wdata[k*DW +: DW] = d;
   endtask

   task automatic do_reset();
      preset = 1'b1;
      sample();
      adv();
      preset = 1'b0;
   endtask

   int acc;
   int ngr;
   int gidx [5];
   int gcyc [5];
   int rs [NR];
   int n_done;
   bit seen;
   logic [NR-1:0] s_done;
   logic [DW-1:0] s_rdata;
   logic          s_err;

   initial begin
      preset = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
      bus.pready_i = 1'b0; bus.prdata_i = '0;
      sample(); adv();
      sample(); adv();
      preset = 1'b0;
      sample();
      check("rst_gnt", 64'(gnt), 64'h0);
      check("rst_psel", 64'(bus.psel_o), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      adv();

      // Single write from requester 0, zero wait states.
      set_req(0, 1'b1, 32'hA000, 32'h5);
      bus.pready_i = 1'b1;
      sample(); check("t1_gnt", 64'(gnt), 64'h1);
      adv(); req = '0;
      sample();
      check("t1_setup_psel", 64'(bus.psel_o), 64'h1);
      check("t1_setup_pen", 64'(bus.penable_o), 64'h0);
      check("t1_paddr", 64'(bus.paddr_o), 64'hA000);
      check("t1_pwrite", 64'(bus.pwrite_o), 64'h1);
      check("t1_pwdata", 64'(bus.pwdata_o), 64'h5);
      adv();
      sample(); check("t1_access_pen", 64'(bus.penable_o), 64'h1);
      adv();
      sample();
      check("t1_done", 64'(done), 64'h1);
      check("t1_err", 64'(err), 64'h0);
      adv();
      sample(); adv();

      // Read from requester 2 with three wait states.
      set_req(2, 1'b0, 32'hA000, 32'hDEAD);
      bus.pready_i = 1'b0; bus.prdata_i = 32'h1234;
      acc = 0;
      sample(); check("t2_gnt", 64'(gnt), 64'h4);
      adv(); req = '0;
      sample(); adv();
      for (int i = 0; i < 3; i++) begin
         sample();
         if (bus.psel_o && bus.penable_o) acc++;
         adv();
      end
      bus.pready_i = 1'b1;
      sample();
      if (bus.psel_o && bus.penable_o) acc++;
      adv();
      bus.pready_i = 1'b0;
      sample();
      check("t2_access_len", 64'(acc), 64'd4);
      check("t2_done", 64'(done), 64'h4);
      check("t2_rdata", 64'(rdata), 64'h1234);
      adv();

      // All four requesters held high: strict rotation, four cycles per transfer.
      do_reset();
      for (int k = 0; k < NR; k++) set_req(k, 1'b1, AW'(32'h100 * k), DW'(k + 1));
      bus.pready_i = 1'b1;
      ngr = 0;
      for (int c = 0; c < 40 && ngr < 5; c++) begin
         sample();
         if (gnt != '0) begin
            for (int k = 0; k < NR; k++) if (gnt[k]) gidx[ngr] = k;
            gcyc[ngr] = cyc;
            ngr++;
         end
         adv();
      end
      check("t3_grants", 64'(ngr), 64'd5);
      for (int i = 0; i < 5; i++) begin
         if (i < ngr) check("t3_order", 64'(gidx[i]), 64'(i % NR));
         if (i > 0 && i < ngr) check("t3_gap", 64'(gcyc[i] - gcyc[i-1]), 64'd4);
      end
      req = '0;
      for (int c = 0; c < 6; c++) begin sample(); adv(); end

      // Reset in the middle of requester 1's ACCESS phase.
      do_reset();
      set_req(1, 1'b1, 32'hB000, 32'h77);
      bus.pready_i = 1'b0;
      sample(); check("t4_gnt", 64'(gnt), 64'h2);
      adv(); req = '0;
      sample(); adv();
      preset = 1'b1;
      sample(); check("t4_access", 64'(bus.penable_o), 64'h1);
      adv();
      preset = 1'b0;
      set_req(1, 1'b1, 32'hB000, 32'h77);
      set_req(0, 1'b0, 32'hC000, 32'h0);
      sample();
      check("t4_psel", 64'(bus.psel_o), 64'h0);
      check("t4_pen", 64'(bus.penable_o), 64'h0);
      check("t4_done", 64'(done), 64'h0);
      check("t4_gnt_after", 64'(gnt), 64'h1);
      adv();
      req[0] = 1'b0; bus.pready_i = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         sample();
         if (e_done[1]) seen = 1'b1;
         adv();
         if (e_gnt[1]) req[1] = 1'b0;
      end
      check("t4_req1_done", 64'(seen), 64'h1);
      bus.pready_i = 1'b0;

      // Long ACCESS: abort under timeout, otherwise a late PREADY completes normally.
      set_req(0, 1'b0, 32'hD000, 32'h0);
      bus.prdata_i = 32'hCAFE;
      acc = 0; seen = 1'b0; s_done = '0; s_rdata = '0; s_err = 1'b0;
      for (int c = 0; c < 200 && !seen; c++) begin
         sample();
         if (bus.psel_o && bus.penable_o) acc++;
         if (done != '0) begin
            seen = 1'b1; s_done = done; s_rdata = rdata; s_err = err;
         end
         adv();
         if (e_gnt[0]) req[0] = 1'b0;
`ifndef APB_TIMEOUT_EN
         if (acc >= 100) bus.pready_i = 1'b1;
`endif
      end
      check("t5_done_seen", 64'(seen), 64'h1);
      check("t5_done", 64'(s_done), 64'h1);
`ifdef APB_TIMEOUT_EN
      check("t5_access_len", 64'(acc), 64'(TMO));
      check("t5_err", 64'(s_err), 64'h1);
      check("t5_rdata", 64'(s_rdata), 64'h0);
      bus.pready_i = 1'b1;
      for (int c = 0; c < 3; c++) begin sample(); adv(); end
`else
      check("t6_access_len", 64'(acc), 64'd101);
      check("t6_err", 64'(s_err), 64'h0);
      check("t6_rdata", 64'(s_rdata), 64'hCAFE);
`endif
      bus.pready_i = 1'b0;

      // Random requesters obeying the hold-until-grant, drop-after-grant protocol.
      req = '0;
      n_done = 0;
      for (int k = 0; k < NR; k++) rs[k] = 0;
      for (int c = 0; c < 3000; c++) begin
         sample();
         for (int k = 0; k < NR; k++) begin
            if (e_gnt[k]) rs[k] = 2;
            if (e_done[k]) begin rs[k] = 0; n_done++; end
            if (preset && rs[k] == 2) rs[k] = 0;
         end
         adv();
         preset       = ($urandom_range(0, 599) == 0);
         bus.pready_i = ($urandom_range(0, 3) != 0);
         bus.prdata_i = $urandom;
         for (int k = 0; k < NR; k++) begin
            if (rs[k] == 2) req[k] = 1'b0;
            else if (rs[k] == 0 && $urandom_range(0, 2) == 0) begin
               rs[k] = 1;
               set_req(k, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end
         end
      end
      check("rand_progress", 64'(n_done > 100), 64'h1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
